// File: rtl/accelerator_vector_write_strength.sv
// Multi-head write strength: beta = 1 + softplus(x) per write head.
// Softplus uses a C1 quadratic join over (-2, 2) and saturates on overflow.
module accelerator_vector_write_strength #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FRACT_SIZE   = DATA_SIZE / 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_W_IN,
  input  logic                    BETA_IN_ENABLE,
  output logic                    BETA_ENABLE,
  input  logic [DATA_SIZE-1:0]    BETA_IN,
  output logic                    BETA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    BETA_OUT
);

  localparam int PW = 2 * DATA_SIZE;
  localparam int SQ_SHIFT = FRACT_SIZE + 3;

  localparam logic [DATA_SIZE-1:0] ONE =
    DATA_SIZE'(1) << FRACT_SIZE;
  localparam logic [DATA_SIZE-1:0] TWO = ONE << 1;
  localparam logic [DATA_SIZE-1:0] NEG_TWO = -TWO;
  localparam logic [DATA_SIZE-1:0] MAX_POS =
    {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] SAT_LIM = MAX_POS - ONE;
  localparam logic [PW-1:0] ONE_W = PW'(ONE);
  localparam logic [PW-1:0] MAX_W = PW'(MAX_POS);

  typedef enum logic [2:0] {
    IDLE,
    INPUT,
    SEGMENT,
    SQUARE,
    OUTPUT,
    FINISH
  } state_t;

  state_t state;

  logic [CONTROL_SIZE-1:0] w_q;
  logic [CONTROL_SIZE-1:0] idx_q;
  logic [DATA_SIZE-1:0]    x_q;
  logic [DATA_SIZE-1:0]    t_q;
  logic                    lin_q;
  logic                    sat_q;

  logic                    is_lo;
  logic                    is_hi;
  logic                    is_sat;
  logic [DATA_SIZE-1:0]    t_nxt;
  logic [PW-1:0]           sq;
  logic [PW-1:0]           quad;
  logic [DATA_SIZE-1:0]    lin_res;
  logic [DATA_SIZE-1:0]    res;
  logic [CONTROL_SIZE-1:0] idx_nxt;
  logic                    last;

  // Region classification of the captured key strength
  always_comb begin
    is_lo  = $signed(x_q) <= $signed(NEG_TWO);
    is_hi  = $signed(x_q) >= $signed(TWO);
    is_sat = $signed(x_q) > $signed(SAT_LIM);
    t_nxt  = (is_lo || is_hi) ? '0 : x_q + TWO;
  end

  // Full-width square, shift and final result select
  always_comb begin
    sq      = PW'(t_q) * PW'(t_q);
    quad    = ONE_W + (sq >> SQ_SHIFT);
    lin_res = sat_q ? MAX_POS : x_q + ONE;
    res     = MAX_POS;
    if (lin_q)
      res = lin_res;
    else if (quad <= MAX_W)
      res = quad[DATA_SIZE-1:0];
  end

  // Head counter compare against the latched head count
  always_comb begin
    idx_nxt = idx_q + CONTROL_SIZE'(1);
    last    = idx_nxt == w_q;
  end

  // Control FSM with registered handshake and data outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= IDLE;
      w_q             <= '0;
      idx_q           <= '0;
      x_q             <= '0;
      t_q             <= '0;
      lin_q           <= 1'b0;
      sat_q           <= 1'b0;
      READY           <= 1'b0;
      BETA_ENABLE     <= 1'b0;
      BETA_OUT_ENABLE <= 1'b0;
      BETA_OUT        <= '0;
    end else begin
      READY           <= 1'b0;
      BETA_OUT_ENABLE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            w_q   <= SIZE_W_IN;
            idx_q <= '0;
            if (SIZE_W_IN == '0) begin
              state <= FINISH;
              READY <= 1'b1;
            end else begin
              state       <= INPUT;
              BETA_ENABLE <= 1'b1;
            end
          end
        end
        INPUT: begin
          if (BETA_IN_ENABLE) begin
            x_q         <= BETA_IN;
            BETA_ENABLE <= 1'b0;
            state       <= SEGMENT;
          end
        end
        SEGMENT: begin
          t_q   <= t_nxt;
          lin_q <= is_hi;
          sat_q <= is_sat;
          state <= SQUARE;
        end
        SQUARE: begin
          BETA_OUT        <= res;
          BETA_OUT_ENABLE <= 1'b1;
          READY           <= last;
          state           <= OUTPUT;
        end
        OUTPUT: begin
          idx_q <= idx_nxt;
          if (last) begin
            state <= IDLE;
          end else begin
            state       <= INPUT;
            BETA_ENABLE <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_vector_write_strength.sv
// Directed bench for the multi-head write strength unit.
// Q8.8 configuration with hand-computed oneplus values.
module tb_accelerator_vector_write_strength;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int FW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          ready;
  logic [CW-1:0] size_w;
  logic          in_en;
  logic          beta_en;
  logic [DW-1:0] beta_in;
  logic          out_en;
  logic [DW-1:0] beta_out;

  int n_checks;
  int n_fails;

  accelerator_vector_write_strength #(
    .DATA_SIZE   (DW),
    .CONTROL_SIZE(CW),
    .FRACT_SIZE  (FW)
  ) dut (
    .CLK            (clk),
    .RST            (rst_n),
    .START          (start),
    .READY          (ready),
    .SIZE_W_IN      (size_w),
    .BETA_IN_ENABLE (in_en),
    .BETA_ENABLE    (beta_en),
    .BETA_IN        (beta_in),
    .BETA_OUT_ENABLE(out_en),
    .BETA_OUT       (beta_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [CW-1:0] w);
    size_w = w;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_enable(input string tag);
    int n;
    n = 0;
    while (!beta_en && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_en_wait"}, 32'(beta_en), 32'd1);
  endtask

  task automatic head(input string tag,
                      input logic [DW-1:0] x,
                      input logic [DW-1:0] exp,
                      input logic last);
    wait_enable(tag);
    beta_in = x;
    in_en   = 1'b1;
    tick();
    in_en   = 1'b0;
    tick();
    tick();
    check({tag, "_oen"}, 32'(out_en), 32'd1);
    check({tag, "_out"}, 32'(beta_out), 32'(exp));
    check({tag, "_rdy"}, 32'(ready), 32'(last));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    size_w   = '0;
    in_en    = 1'b0;
    beta_in  = '0;

    tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_ben", 32'(beta_en), 32'd0);
    check("rst_oen", 32'(out_en), 32'd0);
    check("rst_out", 32'(beta_out), 32'd0);
    rst_n = 1'b1;
    tick();

    start_pass(8'd4);
    check("w4_ben_start", 32'(beta_en), 32'd1);
    head("w4_h0", 16'hFD00, 16'h0100, 1'b0);
    head("w4_h1", 16'h0000, 16'h0180, 1'b0);
    head("w4_h2", 16'h0100, 16'h0220, 1'b0);
    head("w4_h3", 16'h0300, 16'h0400, 1'b1);
    tick();
    check("w4_idle_rdy", 32'(ready), 32'd0);
    check("w4_idle_ben", 32'(beta_en), 32'd0);

    start_pass(8'd2);
    head("bnd_lo", 16'hFE00, 16'h0100, 1'b0);
    head("bnd_hi", 16'h0200, 16'h0300, 1'b1);
    tick();

    start_pass(8'd3);
    head("sat_7f80", 16'h7F80, 16'h7FFF, 1'b0);
    head("sat_7eff", 16'h7EFF, 16'h7FFF, 1'b0);
    head("sat_7e00", 16'h7E00, 16'h7F00, 1'b1);
    tick();

    start_pass(8'd0);
    check("w0_ready", 32'(ready), 32'd1);
    check("w0_oen", 32'(out_en), 32'd0);
    check("w0_ben", 32'(beta_en), 32'd0);
    tick();
    check("w0_ready_drop", 32'(ready), 32'd0);
    check("w0_ben_after", 32'(beta_en), 32'd0);

    start_pass(8'd1);
    beta_in = 16'h0100;
    in_en   = 1'b1;
    tick();
    in_en   = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_ben", 32'(beta_en), 32'd0);
    check("arst_oen", 32'(out_en), 32'd0);
    check("arst_out", 32'(beta_out), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("arst_idle_ben", 32'(beta_en), 32'd0);
    check("arst_idle_oen", 32'(out_en), 32'd0);
    check("arst_idle_rdy", 32'(ready), 32'd0);
    start_pass(8'd1);
    head("arst_w1", 16'h0000, 16'h0180, 1'b1);
    tick();

    start_pass(8'd2);
    check("rob_ben", 32'(beta_en), 32'd1);
    start  = 1'b1;
    size_w = 8'd5;
    tick();
    start  = 1'b0;
    check("rob_start_in", 32'(beta_en), 32'd1);
    beta_in = 16'h0000;
    in_en   = 1'b1;
    tick();
    beta_in = 16'h7E00;
    tick();
    in_en   = 1'b0;
    check("rob_seg_ben", 32'(beta_en), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rob_h0_oen", 32'(out_en), 32'd1);
    check("rob_h0_out", 32'(beta_out), 32'h0180);
    check("rob_h0_rdy", 32'(ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("rob_stall_ben", 32'(beta_en), 32'd1);
      tick();
    end
    check("rob_stall_out", 32'(beta_out), 32'h0180);
    check("rob_stall_oen", 32'(out_en), 32'd0);
    head("rob_h1", 16'h0300, 16'h0400, 1'b1);
    tick();
    check("rob_end_rdy", 32'(ready), 32'd0);
    check("rob_end_ben", 32'(beta_en), 32'd0);
    tick();
    check("rob_end_ben2", 32'(beta_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
